// File: rtl/psram_pkg.sv
// Shared opcodes, FSM states and phase lengths for the quad PSRAM model.
package psram_pkg;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;

  // Address phase is always 24 bits sent as nibbles, MSB nibble first.
  localparam int ADDR_NIBBLES = 6;
  // Wide enough for the longest phase (15 dummy edges).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/psram_mem.sv
// Byte array: synchronous write on sck, combinational read.
module psram_mem #(
  parameter int ADDR_W = 22
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:(1<<ADDR_W)-1];

  // Commit one full byte per write strobe.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/psram_qpi_model.sv
// Behavioural quad-I/O PSRAM: SPI/QPI command phase, quad address/data.
module psram_qpi_model
  import psram_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int DUMMY_CYCLES = 7,
  parameter bit INIT_QPI     = 1'b0
) (
  input  logic       sck,
  input  logic       rst_n,
  input  logic       ce_n,
  inout  wire  [3:0] dio,
  output logic       qpi_mode
);

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [7:0]          r_cmd, w_cmd_nx, w_cmd_sh;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [3:0]          r_hold, w_hold_nx;
  logic                r_qpi, w_qpi_nx;
  logic                r_rst_en, w_rst_en_nx;
  logic                w_cmd_last;
  logic                w_we;
  logic                w_oe;
  logic [7:0]          w_rdata;
  logic [3:0]          w_dout;

  psram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .i_clk   (sck),
    .i_we    (w_we & ~ce_n),
    .i_waddr (r_addr),
    .i_wdata ({r_hold, dio}),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  // Next-state, counters and command decode; counter clears on every state change.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + 1'b1;
    w_cmd_nx    = r_cmd;
    w_addr_nx   = r_addr;
    w_hold_nx   = r_hold;
    w_qpi_nx    = r_qpi;
    w_rst_en_nx = r_rst_en;
    w_we        = 1'b0;
    w_cmd_sh    = r_qpi ? {r_cmd[3:0], dio} : {r_cmd[6:0], dio[0]};
    w_cmd_last  = r_qpi ? (r_cnt == CNT_W'(1)) : (r_cnt == CNT_W'(7));
    case (r_state)
      ST_CMD: begin
        w_cmd_nx = w_cmd_sh;
        if (w_cmd_last) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_IGNORE;
          case (w_cmd_sh)
            CMD_QREAD, CMD_QWRITE: w_state_nx = ST_ADDR;
            CMD_QPI_EN: w_qpi_nx    = 1'b1;
            CMD_QPI_EX: w_qpi_nx    = 1'b0;
            CMD_RST_EN: w_rst_en_nx = 1'b1;
            CMD_RST: begin
              if (r_rst_en) w_qpi_nx = INIT_QPI;
              w_rst_en_nx = 1'b0;
            end
            default: w_rst_en_nx = 1'b0;
          endcase
        end
      end
      ST_ADDR: begin
        // Shifting through an ADDR_W register truncates the 24-bit address.
        w_addr_nx = ADDR_W'({r_addr, dio});
        if (r_cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
          w_cnt_nx   = '0;
          w_state_nx = (r_cmd == CMD_QREAD) ? ST_DUMMY : ST_WRITE;
        end
      end
      ST_DUMMY: begin
        if (r_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_READ;
        end
      end
      ST_READ: begin
        if (r_cnt[0]) begin
          w_cnt_nx  = '0;
          w_addr_nx = r_addr + 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_cnt == '0) begin
          w_hold_nx = dio;
        end else begin
          w_we      = 1'b1;
          w_cnt_nx  = '0;
          w_addr_nx = r_addr + 1'b1;
        end
      end
      default: w_cnt_nx = r_cnt;
    endcase
  end

  // State register: rst_n resets everything, ce_n high aborts but keeps mode.
  always_ff @(posedge sck or negedge rst_n or posedge ce_n) begin
    if (!rst_n) begin
      r_state  <= ST_CMD;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_hold   <= '0;
      r_qpi    <= INIT_QPI;
      r_rst_en <= 1'b0;
    end else if (ce_n) begin
      r_state  <= ST_CMD;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_cmd    <= w_cmd_nx;
      r_addr   <= w_addr_nx;
      r_hold   <= w_hold_nx;
      r_qpi    <= w_qpi_nx;
      r_rst_en <= w_rst_en_nx;
    end
  end

  assign w_oe     = (r_state == ST_READ);
  assign w_dout   = r_cnt[0] ? w_rdata[3:0] : w_rdata[7:4];
  assign dio      = w_oe ? w_dout : 4'bzzzz;
  assign qpi_mode = r_qpi;

endmodule

// File: tb/tb_psram_qpi_model.sv
// Directed bench for the quad PSRAM model.
module tb_psram_qpi_model;

  logic       sck, rst_n, ce_n;
  logic       qpi_mode;
  logic       tb_oe;
  logic [3:0] tb_dio;
  tri   [3:0] dio;

  int n_tests = 0;
  int n_fail  = 0;

  assign dio = tb_oe ? tb_dio : 4'bzzzz;

  psram_qpi_model #(.ADDR_W(22), .DUMMY_CYCLES(7), .INIT_QPI(1'b0)) dut (
    .sck      (sck),
    .rst_n    (rst_n),
    .ce_n     (ce_n),
    .dio      (dio),
    .qpi_mode (qpi_mode)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edge_nib(input logic [3:0] v);
    tb_oe = 1'b1; tb_dio = v;
    #5 sck = 1'b1;
    #5 sck = 1'b0;
  endtask

  task automatic edge_rel();
    tb_oe = 1'b0;
    #5 sck = 1'b1;
    #5 sck = 1'b0;
  endtask

  task automatic start();
    ce_n = 1'b0; #5;
  endtask

  task automatic stop();
    tb_oe = 1'b0; ce_n = 1'b1; #5;
  endtask

  task automatic send_cmd(input logic [7:0] c, input bit qpi);
    if (qpi) begin
      edge_nib(c[7:4]);
      edge_nib(c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) edge_nib({3'b000, c[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) edge_nib(a[i*4 +: 4]);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    edge_nib(b[7:4]);
    edge_nib(b[3:0]);
  endtask

  task automatic rd_hdr(input bit qpi, input logic [23:0] a);
    start();
    send_cmd(8'hEB, qpi);
    send_addr(a);
    for (int i = 0; i < 7; i++) edge_rel();
  endtask

  // Data is combinational from state, so sample while sck is low, then clock.
  task automatic rd_byte(output logic [7:0] b);
    tb_oe = 1'b0;
    #1 b[7:4] = dio;
    edge_rel();
    #1 b[3:0] = dio;
    edge_rel();
  endtask

  task automatic wr_txn(input bit qpi, input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    start();
    send_cmd(8'h38, qpi);
    send_addr(a);
    wr_byte(b0);
    wr_byte(b1);
    stop();
  endtask

  task automatic one_cmd(input logic [7:0] c, input bit qpi);
    start();
    send_cmd(c, qpi);
    stop();
  endtask

  logic [7:0] b;

  initial begin
    sck = 1'b0; ce_n = 1'b1; rst_n = 1'b0; tb_oe = 1'b0; tb_dio = 4'h0;
    #12;
    chk("rst_qpi", 32'(qpi_mode), 32'd0);
    chk("rst_oe", 32'(dut.w_oe), 32'd0);
    rst_n = 1'b1; #5;

    // SPI write then read
    wr_txn(1'b0, 24'h000010, 8'hA5, 8'h3C);
    chk("spi_wr_qpi", 32'(qpi_mode), 32'd0);
    rd_hdr(1'b0, 24'h000010);
    chk("rd_oe_on", 32'(dut.w_oe), 32'd1);
    rd_byte(b);
    chk("spi_rd_n0", 32'(b[7:4]), 32'hA);
    chk("spi_rd_n1", 32'(b[3:0]), 32'h5);
    rd_byte(b);
    chk("spi_rd_n2", 32'(b[7:4]), 32'h3);
    chk("spi_rd_n3", 32'(b[3:0]), 32'hC);
    stop();
    chk("rd_oe_off", 32'(dut.w_oe), 32'd0);
    chk("spi_rd_qpi", 32'(qpi_mode), 32'd0);

    // QPI entry, QPI read, exit
    one_cmd(8'h35, 1'b0);
    chk("qpi_en", 32'(qpi_mode), 32'd1);
    rd_hdr(1'b1, 24'h000010);
    rd_byte(b);
    stop();
    chk("qpi_rd", 32'(b), 32'hA5);
    one_cmd(8'hF5, 1'b1);
    chk("qpi_ex", 32'(qpi_mode), 32'd0);

    // Address wrap at top of array
    wr_txn(1'b0, 24'h3FFFFF, 8'h11, 8'h22);
    rd_hdr(1'b0, 24'h3FFFFF);
    rd_byte(b); chk("wrap_rd0", 32'(b), 32'h11);
    rd_byte(b); chk("wrap_rd1", 32'(b), 32'h22);
    stop();
    rd_hdr(1'b0, 24'h000000);
    rd_byte(b); chk("wrap_mem0", 32'(b), 32'h22);
    stop();

    // Partial-byte abort leaves the next byte untouched
    wr_txn(1'b0, 24'h000020, 8'h00, 8'hEE);
    start();
    send_cmd(8'h38, 1'b0);
    send_addr(24'h000020);
    wr_byte(8'h77);
    edge_nib(4'h9);
    stop();
    chk("abort_oe", 32'(dut.w_oe), 32'd0);
    rd_hdr(1'b0, 24'h000020);
    rd_byte(b); chk("abort_b0", 32'(b), 32'h77);
    rd_byte(b); chk("abort_b1", 32'(b), 32'hEE);
    stop();

    // Reset sequence and unknown opcode
    one_cmd(8'h35, 1'b0);
    one_cmd(8'h99, 1'b1);
    chk("rst_alone", 32'(qpi_mode), 32'd1);
    one_cmd(8'h66, 1'b1);
    chk("rst_en_hold", 32'(qpi_mode), 32'd1);
    one_cmd(8'h99, 1'b1);
    chk("rst_seq", 32'(qpi_mode), 32'd0);
    start();
    send_cmd(8'h02, 1'b0);
    for (int i = 0; i < 20; i++) edge_nib(4'(i));
    chk("unk_oe", 32'(dut.w_oe), 32'd0);
    stop();
    rd_hdr(1'b0, 24'h000010);
    rd_byte(b); chk("unk_mem0", 32'(b), 32'hA5);
    rd_byte(b); chk("unk_mem1", 32'(b), 32'h3C);
    stop();

    // Async reset in the middle of a QPI read
    one_cmd(8'h35, 1'b0);
    rd_hdr(1'b1, 24'h000010);
    #1 b[7:4] = dio;
    chk("ar_pre_nib", 32'(b[7:4]), 32'hA);
    rst_n = 1'b0; #1;
    chk("ar_oe", 32'(dut.w_oe), 32'd0);
    chk("ar_qpi", 32'(qpi_mode), 32'd0);
    ce_n = 1'b1; #5;
    rst_n = 1'b1; #5;
    rd_hdr(1'b0, 24'h000010);
    rd_byte(b); chk("ar_rd", 32'(b), 32'hA5);
    stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_qpi_model.md
Name: psram_qpi_model

Overview:
- Parametrised behavioural model of a quad-I/O PSRAM device, sitting on the SoC PSRAM controller's sck/ce_n/dio pins as the simulated external memory.
- Successor to the fixed 4 MiB SPI-command-only model, adding:
  - parametrised depth and read dummy count;
  - QPI mode, with 4-bit command phase entered and exited by command;
  - software reset command;
  - explicit address wrap and a defined abort rule;
  - an asynchronous active-low power-on reset.

Parameters:
- ADDR_W, 22: byte-address width; array depth = 2**ADDR_W bytes; the 24-bit bus address is truncated to ADDR_W LSBs.
- DUMMY_CYCLES, 7: sck rising edges between the last address nibble and the first read data nibble; legal range 1..15.
- INIT_QPI, 0: value of qpi_mode after rst_n.

Ports:
- sck, input, 1: device clock; all sampling on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- ce_n, input, 1: chip enable, active low; the rising edge aborts the transaction asynchronously.
- dio, inout, 4: quad data; dio[0] carries the serial command in SPI mode.
- qpi_mode, output, 1: current command-phase mode (1 = QPI); observability only.

Behaviour:
- Reset (rst_n=0, async): state=CMD, counter=0, cmd=0, addr=0, qpi_mode=INIT_QPI, reset_en=0, dio released (oe=0). Memory contents are untouched.
- ce_n high (async): state=CMD, counter=0, cmd=0, addr=0, pending nibble discarded, oe=0. qpi_mode and reset_en are kept.
- FSM states: CMD, ADDR, DUMMY, READ, WRITE, IGNORE. One counter, cleared on every state change.
- CMD phase:
  - SPI mode: 8 edges, MSB first on dio[0].
  - QPI mode: 2 edges, high nibble first on dio[3:0].
- After the last CMD edge:
  - 0xEB (read) or 0x38 (write): go to ADDR.
  - 0x35: set qpi_mode=1, go to IGNORE.
  - 0xF5: set qpi_mode=0, go to IGNORE.
  - 0x66: set reset_en=1, go to IGNORE.
  - 0x99 with reset_en=1: qpi_mode=INIT_QPI, reset_en=0, go to IGNORE.
  - Any other opcode (including 0x99 without reset_en): reset_en=0, go to IGNORE.
  - The mode change takes effect for the next transaction, since ce_n must toggle.
- ADDR: 6 edges, nibble-wise, MSB nibble first on dio[3:0]. After the 6th edge: 0xEB goes to DUMMY, 0x38 goes to WRITE.
- DUMMY: DUMMY_CYCLES edges with dio ignored, then READ.
- READ:
  - oe=4'hF for the whole state.
  - dio = high nibble of mem[addr] while the nibble counter = 0, low nibble while = 1. Output is combinational from state, so data is valid before the controller's next sampling edge.
  - The edge that ends the low nibble increments addr.
- WRITE:
  - The first edge latches the high nibble into a holding register.
  - The second edge writes {hold, dio} to mem[addr] as one byte and increments addr.
  - A byte is committed only when both nibbles have been received; a ce_n rise after one nibble leaves memory unchanged.
- Address wrap: addr increments modulo 2**ADDR_W, so the last byte is followed by byte 0.
- IGNORE: dio is ignored and oe=0 until ce_n rises.
- Burst length is unlimited in READ and WRITE; the transaction ends only on ce_n.
- rst_n asserted mid-burst: immediate abort, identical to the ce_n rule, plus the mode reset.
- Simultaneous ce_n rise and sck rise: ce_n wins; no commit and no state advance.
- oe is 0 in every state except READ, so the bus is never driven during CMD or ADDR.

Decomposition:
- Shared package psram_pkg:
  - opcode constants CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_QPI_EN=8'h35, CMD_QPI_EX=8'hF5, CMD_RST_EN=8'h66, CMD_RST=8'h99;
  - state enum;
  - address-phase nibble count (6).
- Sub-module psram_mem: byte array of depth 2**ADDR_W, one synchronous write port (sck), one combinational read port. The top holds the FSM, counters, address register and tri-state logic.

Test Plan:
- SPI write then read: rst_n pulse; in SPI mode write 0x38, addr 0x000010, bytes A5 3C; then 0xEB, same addr, 7 dummy edges -> dio returns A,5,3,C; qpi_mode=0 throughout.
- QPI entry: in SPI mode send 0x35, toggle ce_n -> qpi_mode=1. Then in QPI mode send 2-nibble 0xEB, addr 0x000010 -> reads A5. Then send 0xF5 -> qpi_mode=0.
- Wrap, ADDR_W=22: write 0x38 at addr 0x3FFFFF with bytes 11 22 -> mem[0x3FFFFF]=11, mem[0]=22. A read from 0x3FFFFF returns 11 then 22.
- Partial-byte abort: write 0x38 at addr 0x20; one full byte 77, then one nibble 9, then ce_n rise -> mem[0x20]=77, mem[0x21] unchanged; oe=0 after the abort.
- Reset sequence and unknown opcode:
  - In QPI, 0x99 alone -> qpi_mode stays 1.
  - 0x66 then 0x99 -> qpi_mode=INIT_QPI=0.
  - Opcode 0x02 followed by 20 edges of driven dio -> no memory change, oe=0.
- Async reset mid-read: rst_n=0 while a read is in the READ state -> oe=0 the same instant, qpi_mode=INIT_QPI. A fresh read then returns the previously written data.
